// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: combinational ROM port, redirect/halt controls and the decode-side
// valid/ready handshake. The master side is the fetch controller.
interface fetch_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0]    rom_data;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic                     halt;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect,
    input  redirect_target,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect,
    output redirect_target,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the PC, buffers {pc, instr} pairs for decode and applies
// branch redirects and halt stalls. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_ctrl #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned              BUF_DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  fetch_ctrl_if.master                     bus,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
  output logic                             misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [ADDRESS_WIDTH-1:0]         perf_fetch_cnt,
  output logic [ADDRESS_WIDTH-1:0]         perf_stall_cnt,
  output logic [ADDRESS_WIDTH-1:0]         perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IW = $clog2(BUF_DEPTH);
  localparam logic [CW-1:0] Full = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     valid_q;
  logic                     misalign_q;
  logic [DATA_WIDTH-1:0]    instr_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_d [BUF_DEPTH];
  logic [ADDRESS_WIDTH-1:0] epc_q   [BUF_DEPTH];
  logic [ADDRESS_WIDTH-1:0] epc_d   [BUF_DEPTH];

  logic          pop, push, space;
  logic [CW-1:0] wr_idx;

  assign pop   = valid_q & bus.out_ready;
  // A full buffer still has room when the head leaves this cycle.
  assign space = (count_q != Full) | pop;
  assign push  = (state_q == StFetch) & space & ~bus.halt & ~bus.redirect;

  // Shift FIFO: slot 0 is always the head, so out_* come straight from registers.
  always_comb begin
    instr_d = instr_q;
    epc_d   = epc_q;
    count_d = count_q;
    wr_idx  = pop ? count_q - CW'(1) : count_q;
    if (bus.redirect) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) begin
          instr_d[i] = instr_q[i+1];
          epc_d[i]   = epc_q[i+1];
        end
      end
      if (push) begin
        instr_d[wr_idx[IW-1:0]] = bus.rom_data;
        epc_d[wr_idx[IW-1:0]]   = pc_q;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '{default: '0};
      epc_q      <= '{default: '0};
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      instr_q <= instr_d;
      epc_q   <= epc_d;
      if (bus.redirect) begin
        pc_q    <= {bus.redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
        state_q <= bus.halt ? StHold : StFetch;
        if (bus.redirect_target[1:0] != 2'b00) begin
          misalign_q <= 1'b1;
        end
      end else begin
        if (push) begin
          pc_q <= pc_q + ADDRESS_WIDTH'(4);
        end
        unique case (state_q)
          StIdle:  state_q <= bus.halt ? StHold : StFetch;
          StFetch: if (bus.halt || !space) state_q <= StHold;
          StHold:  if (!bus.halt && space) state_q <= StFetch;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q[0];
  assign bus.out_pc    = epc_q[0];
  assign buf_count     = count_q;
  assign misalign_err  = misalign_q;

`ifdef FETCH_PERF_EN
  logic [ADDRESS_WIDTH-1:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push && perf_fetch_q != '1) begin
        perf_fetch_q <= perf_fetch_q + ADDRESS_WIDTH'(1);
      end
      if (state_q == StHold && !bus.halt && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + ADDRESS_WIDTH'(1);
      end
      if (bus.redirect && count_q != '0 && perf_flush_q != '1) begin
        perf_flush_q <= perf_flush_q + ADDRESS_WIDTH'(1);
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the program counter and instruction ROM for the fetch stage.
- Drives the ROM address, captures each instruction with its PC into a small registered buffer, and presents it to decode over a valid/ready handshake.
- Applies taken-branch redirects: flushes the buffer and reloads the PC.
- Applies halt/backpressure stalls.

Parameters:
ADDRESS_WIDTH, 32, PC and ROM address width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, fetch buffer entries; legal values 2 or 4

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
rom_addr  output  ADDRESS_WIDTH  address to combinational instruction ROM
rom_data  input  DATA_WIDTH  ROM read data, valid in the same cycle as rom_addr
redirect  input  1  taken branch/jump (PCsrc), single-cycle pulse
redirect_target  input  ADDRESS_WIDTH  new PC (PC+ImmOp, computed upstream)
halt  input  1  level; suppresses new fetches while high
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  DATA_WIDTH  instruction at buffer head
out_pc  output  ADDRESS_WIDTH  PC of instruction at head
buf_count  output  $clog2(BUF_DEPTH+1)  occupied entries
misalign_err  output  1  sticky; set by a redirect target with [1:0] != 0

Behaviour:
Reset (rst=0 at a rising edge):
- pc = RESET_PC; state = IDLE.
- Buffer emptied: buf_count = 0, out_valid = 0.
- out_instr and out_pc = 0; misalign_err = 0.
- Reset mid-operation discards all buffered entries.

Address path:
- rom_addr = pc combinationally at all times.
- No combinational path from rom_data or redirect to any out_* port; all out_* ports are registered.

FSM states:
- IDLE: no push. First edge with rst=1 goes to FETCH if halt=0, else HOLD.
- FETCH: push {pc, rom_data} when space exists, then pc <= pc+4.
  - Space exists when buf_count < BUF_DEPTH, or when buffer is full and a pop occurs the same cycle.
  - Go to HOLD if no space or halt=1.
- HOLD: no push, pc holds. Return to FETCH when halt=0 and space exists.

Handshake:
- pop = out_valid & out_ready.
- out_valid = (buf_count != 0).
- Once high, out_valid and the head stay stable until pop or flush.
- Entries leave in FIFO order.
- Simultaneous push and pop leaves buf_count unchanged.

Redirect (highest priority, overrides push, pop and halt):
- pc <= {redirect_target[AW-1:2], 2'b00}.
- Buffer flushed: buf_count = 0 and out_valid = 0 on the next cycle.
- No push that cycle.
- A pop coincident with a redirect is still accepted by decode (handshake complete), and the flush applies.
- Next state: FETCH, or HOLD if halt=1.
- If redirect_target[1:0] != 0, misalign_err is set and stays set until reset.

Arithmetic:
- pc+4 wraps modulo 2^ADDRESS_WIDTH; 32'hFFFF_FFFC is followed by 0.

Latency:
- Edge 1 after release: IDLE->FETCH.
- Edge 2: push of RESET_PC.
- out_valid high after edge 2.
- Redirect to first valid target instruction: 2 edges.

Halt:
- Halt only blocks pushes; buffered entries still drain to decode.

Optional Feature:
Macro FETCH_PERF_EN.
- When defined, adds three outputs, each ADDRESS_WIDTH wide:
  - perf_fetch_cnt: pushes.
  - perf_stall_cnt: cycles in HOLD with halt=0.
  - perf_flush_cnt: redirects that discarded at least one entry.
- All three reset to 0 and saturate at all-ones.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, halt=0, out_ready=1 constantly -> out_valid rises after edge 2 with out_pc 0x0, then 0x4, 0x8 on consecutive cycles; instructions match ROM words 0,1,2.
- out_ready=0 for 6 cycles after reset (BUF_DEPTH=2) -> buf_count saturates at 2, rom_addr holds 0x8, state HOLD. Raising out_ready then yields PCs 0x0, 0x4, 0x8 with no gap and no duplicate.
- Buffer holds 2 entries, redirect=1 with target 0x40 and out_ready=1 the same cycle -> next cycle out_valid=0, buf_count=0. Next valid out_pc is 0x40, and the old entries never reappear.
- Redirect with target 0x42 -> misalign_err=1 thereafter; fetch resumes at 0x40. misalign_err clears only on reset.
- pc forced near top via redirect to 0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- halt=1 for 4 cycles while buffer holds 1 entry, out_ready=1 -> entry drains, out_valid=0, rom_addr constant. Deasserting halt resumes from the held pc. rst=0 mid-stream empties the buffer and reloads RESET_PC.
